// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to the instruction memory port,
// parks one returned word while decode is stalled, and absorbs branch
// redirects, including redirects that arrive while a read is still in flight.
// Drives the IF/ID register (PC, instruction word, bubble flag).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h4000_0060
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_n,
  input  logic        br_flush,
  input  logic [31:0] br_target,
  output logic        imem_read,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_rdata,
  input  logic        imem_resp,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic        nop_en,
  output logic        fetch_busy
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // S_REQ:     read issued at pc, waiting for (or receiving) the response
  // S_HOLD:    word parked in buf_q until decode can take it
  // S_DISCARD: redirected while a read was outstanding; wait it out, drop it
  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_DISCARD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] tgt_q, tgt_d;

  logic        ifid_load;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_nop;

  // Memory-side outputs: address always word aligned, no request during reset
  // or while a word is parked.
  assign imem_read    = rst && (state_q != S_HOLD);
  assign imem_address = {pc_q[31:2], 2'b00};
  assign fetch_busy   = (state_q != S_HOLD) && !imem_resp;

  // Next-state, next-PC and IF/ID load decision; branch flush beats stall.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    buf_d      = buf_q;
    tgt_d      = tgt_q;
    // Unless a case below supplies a real instruction, IF/ID takes a bubble
    // whenever decode is able to accept something.
    ifid_load  = stall_n;
    ifid_pc    = 32'h0;
    ifid_instr = NOP_INSTR;
    ifid_nop   = 1'b1;

    unique case (state_q)
      S_REQ: begin
        if (imem_resp && br_flush) begin
          pc_d = br_target;
        end else if (imem_resp && stall_n) begin
          ifid_pc    = pc_q;
          ifid_instr = imem_rdata;
          ifid_nop   = 1'b0;
          pc_d       = pc_q + 32'd4;
        end else if (imem_resp) begin
          buf_d   = imem_rdata;
          state_d = S_HOLD;
        end else if (br_flush) begin
          // Address must stay stable until the pending response, so the
          // redirect is remembered rather than applied.
          tgt_d   = br_target;
          state_d = S_DISCARD;
        end
      end

      S_HOLD: begin
        if (br_flush) begin
          pc_d    = br_target;
          state_d = S_REQ;
        end else if (stall_n) begin
          ifid_pc    = pc_q;
          ifid_instr = buf_q;
          ifid_nop   = 1'b0;
          pc_d       = pc_q + 32'd4;
          state_d    = S_REQ;
        end
      end

      S_DISCARD: begin
        if (imem_resp) begin
          pc_d    = br_flush ? br_target : tgt_q;
          state_d = S_REQ;
        end else if (br_flush) begin
          tgt_d = br_target;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  // Fetch state: FSM, PC, parked word and pending redirect target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      buf_q   <= 32'h0;
      tgt_q   <= 32'h0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      tgt_q   <= tgt_d;
    end
  end

  // IF/ID pipeline register; holds its contents while decode is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_out    <= 32'h0;
      instr_out <= NOP_INSTR;
      nop_en    <= 1'b1;
    end else if (ifid_load) begin
      pc_out    <= ifid_pc;
      instr_out <= ifid_instr;
      nop_en    <= ifid_nop;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus a randomized run
// scored against a program-order model (expected PC stream and memory image).
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h4000_0060;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_n = 1'b0;
  logic        br_flush = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_resp = 1'b0;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic        nop_en;
  logic        fetch_busy;

  int tests  = 0;
  int failed = 0;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_n      (stall_n),
    .br_flush     (br_flush),
    .br_target    (br_target),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_rdata   (imem_rdata),
    .imem_resp    (imem_resp),
    .pc_out       (pc_out),
    .instr_out    (instr_out),
    .nop_en       (nop_en),
    .fetch_busy   (fetch_busy)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Memory image: the word stored at the aligned address containing a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic test_reset;
    rst = 1'b0; stall_n = 1'b0; imem_resp = 1'b0; br_flush = 1'b0;
    tick; tick;
    tests++; if (pc_out !== 32'h0) begin failed++; $display("FAIL reset_pc_out: got %h want %h", pc_out, 32'h0); end
    tests++; if (instr_out !== 32'h13) begin failed++; $display("FAIL reset_instr: got %h want %h", instr_out, 32'h13); end
    tests++; if (nop_en !== 1'b1) begin failed++; $display("FAIL reset_nop: got %b want 1", nop_en); end
    tests++; if (imem_read !== 1'b0) begin failed++; $display("FAIL reset_read: got %b want 0", imem_read); end
    rst = 1'b1;
    #1;
    tests++; if (imem_read !== 1'b1) begin failed++; $display("FAIL release_read: got %b want 1", imem_read); end
    tests++; if (imem_address !== RESET_PC) begin failed++; $display("FAIL release_addr: got %h want %h", imem_address, RESET_PC); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_pc;
    exp_pc = RESET_PC;
    stall_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imem_resp  = 1'b1;
      imem_rdata = 32'hA0 + 32'(i);
      tick;
      tests++; if (pc_out !== exp_pc) begin failed++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, pc_out, exp_pc); end
      tests++; if (instr_out !== 32'hA0 + 32'(i)) begin failed++; $display("FAIL b2b_instr[%0d]: got %h want %h", i, instr_out, 32'hA0 + 32'(i)); end
      tests++; if (nop_en !== 1'b0) begin failed++; $display("FAIL b2b_nop[%0d]: got %b want 0", i, nop_en); end
      exp_pc = exp_pc + 32'd4;
      tests++; if (imem_address !== exp_pc) begin failed++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, imem_address, exp_pc); end
    end
    imem_resp = 1'b0;
  endtask

  task automatic test_stall_at_response;
    // pc is RESET_PC + 0xC; IF/ID holds the A2 fetch at RESET_PC + 8.
    stall_n = 1'b0; imem_resp = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_resp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (imem_read !== 1'b0) begin failed++; $display("FAIL stall_read[%0d]: got %b want 0", i, imem_read); end
      tests++; if ({pc_out, instr_out, nop_en} !== {RESET_PC + 32'd8, 32'hA2, 1'b0}) begin
        failed++; $display("FAIL stall_hold[%0d]: got %h/%h/%b want %h/%h/0", i, pc_out, instr_out, nop_en, RESET_PC + 32'd8, 32'hA2);
      end
      if (i == 0) tick;
    end
    stall_n = 1'b1;
    tick;
    tests++; if (instr_out !== 32'hDEAD_BEEF || pc_out !== RESET_PC + 32'hC || nop_en !== 1'b0) begin
      failed++; $display("FAIL stall_release: got %h/%h/%b want %h/deadbeef/0", pc_out, instr_out, nop_en, RESET_PC + 32'hC);
    end
    tests++; if (imem_address !== RESET_PC + 32'h10 || imem_read !== 1'b1) begin
      failed++; $display("FAIL stall_next_addr: got %h read %b want %h", imem_address, imem_read, RESET_PC + 32'h10);
    end
  endtask

  task automatic test_flush_during_miss;
    stall_n = 1'b1;
    // Redirect to 0x100 using a response-coincident flush.
    imem_resp = 1'b1; imem_rdata = 32'hBAD0; br_flush = 1'b1; br_target = 32'h100;
    tick;
    br_flush = 1'b0; imem_resp = 1'b0;
    #1;
    tests++; if (imem_address !== 32'h100) begin failed++; $display("FAIL miss_addr100: got %h want 100", imem_address); end
    tick;
    br_flush = 1'b1; br_target = 32'h200;
    tick;
    br_target = 32'h300;
    tick;
    br_flush = 1'b0;
    #1;
    tests++; if (imem_address !== 32'h100 || imem_read !== 1'b1 || fetch_busy !== 1'b1) begin
      failed++; $display("FAIL miss_discard_hold: got addr %h read %b busy %b want 100/1/1", imem_address, imem_read, fetch_busy);
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin imem_resp = 1'b1; imem_rdata = 32'h1234; end
      tick;
      tests++; if (nop_en !== 1'b1 || instr_out === 32'h1234) begin
        failed++; $display("FAIL miss_bubble[%0d]: got nop %b instr %h want nop 1", i, nop_en, instr_out);
      end
    end
    imem_resp = 1'b0;
    #1;
    tests++; if (imem_address !== 32'h300 || imem_read !== 1'b1) begin
      failed++; $display("FAIL miss_latest_target: got %h read %b want 300", imem_address, imem_read);
    end
    imem_resp = 1'b1; imem_rdata = 32'h3000_0001;
    tick;
    imem_resp = 1'b0;
    tests++; if (pc_out !== 32'h300 || instr_out !== 32'h3000_0001 || nop_en !== 1'b0) begin
      failed++; $display("FAIL miss_first_fetch: got %h/%h/%b want 300/30000001/0", pc_out, instr_out, nop_en);
    end
  endtask

  task automatic test_flush_with_resp;
    stall_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h5555; br_flush = 1'b1; br_target = 32'h800;
    tick;
    br_flush = 1'b0; imem_resp = 1'b0;
    tests++; if (nop_en !== 1'b1 || instr_out === 32'h5555) begin
      failed++; $display("FAIL coinc_bubble: got nop %b instr %h want nop 1", nop_en, instr_out);
    end
    #1;
    tests++; if (imem_address !== 32'h800) begin failed++; $display("FAIL coinc_addr: got %h want 800", imem_address); end
  endtask

  task automatic test_wrap;
    stall_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h1; br_flush = 1'b1; br_target = 32'hFFFF_FFFC;
    tick;
    br_flush = 1'b0; imem_rdata = 32'hCAFE;
    #1;
    tests++; if (imem_address !== 32'hFFFF_FFFC) begin failed++; $display("FAIL wrap_addr: got %h want fffffffc", imem_address); end
    tick;
    imem_resp = 1'b0;
    tests++; if (pc_out !== 32'hFFFF_FFFC || instr_out !== 32'hCAFE || nop_en !== 1'b0) begin
      failed++; $display("FAIL wrap_ifid: got %h/%h/%b want fffffffc/cafe/0", pc_out, instr_out, nop_en);
    end
    #1;
    tests++; if (imem_address !== 32'h0) begin failed++; $display("FAIL wrap_next: got %h want 0", imem_address); end
  endtask

  task automatic test_unaligned_target;
    stall_n = 1'b1; imem_resp = 1'b1; imem_rdata = 32'h2; br_flush = 1'b1; br_target = 32'h203;
    tick;
    br_flush = 1'b0; imem_rdata = 32'hB0B;
    #1;
    tests++; if (imem_address !== 32'h200) begin failed++; $display("FAIL unal_addr: got %h want 200", imem_address); end
    tick;
    imem_resp = 1'b0;
    tests++; if (pc_out !== 32'h203 || instr_out !== 32'hB0B) begin
      failed++; $display("FAIL unal_ifid: got %h/%h want 203/b0b", pc_out, instr_out);
    end
    #1;
    tests++; if (imem_address !== 32'h204) begin failed++; $display("FAIL unal_next: got %h want 204", imem_address); end
  endtask

  task automatic test_reset_mid_request;
    stall_n = 1'b1; imem_resp = 1'b0; br_flush = 1'b1; br_target = 32'h500;
    tick;
    br_flush = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    tests++; if (imem_read !== 1'b0 || nop_en !== 1'b1 || pc_out !== 32'h0) begin
      failed++; $display("FAIL midreset_async: got read %b nop %b pc %h want 0/1/0", imem_read, nop_en, pc_out);
    end
    tick;
    rst = 1'b1;
    #1;
    tests++; if (imem_address !== RESET_PC || imem_read !== 1'b1 || fetch_busy !== 1'b1) begin
      failed++; $display("FAIL midreset_restart: got %h read %b busy %b want %h/1/1", imem_address, imem_read, fetch_busy, RESET_PC);
    end
    imem_resp = 1'b1; imem_rdata = 32'h77;
    tick;
    imem_resp = 1'b0;
    tests++; if (pc_out !== RESET_PC || instr_out !== 32'h77 || nop_en !== 1'b0) begin
      failed++; $display("FAIL midreset_fetch: got %h/%h/%b want %h/77/0", pc_out, instr_out, nop_en, RESET_PC);
    end
  endtask

  // Random stall/flush/latency traffic. The model only knows program order:
  // the next delivered instruction sits at exp_pc, which advances by 4 per
  // delivery and jumps to the latest flush target.
  task automatic test_random;
    logic [31:0] exp_pc, req_addr, tgt_r, snap_pc, snap_instr;
    logic        snap_nop, outstanding, prev_flush, prev_stall, prev_resp;
    int          wait_cnt, delivered;
    rst = 1'b0; stall_n = 1'b0; br_flush = 1'b0; imem_resp = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    exp_pc = RESET_PC; outstanding = 1'b0; wait_cnt = 0; delivered = 0; req_addr = 32'h0;
    prev_flush = 1'b0; prev_stall = 1'b0; prev_resp = 1'b0; tgt_r = 32'h0;
    snap_pc = pc_out; snap_instr = instr_out; snap_nop = nop_en;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (prev_resp) outstanding = 1'b0;
      if (!prev_stall) begin
        tests++; if ({pc_out, instr_out, nop_en} !== {snap_pc, snap_instr, snap_nop}) begin
          failed++; $display("FAIL rnd_stall_hold @%0d: got %h/%h/%b want %h/%h/%b", cyc, pc_out, instr_out, nop_en, snap_pc, snap_instr, snap_nop);
        end
      end else if (prev_flush) begin
        tests++; if (nop_en !== 1'b1) begin failed++; $display("FAIL rnd_flush_bubble @%0d: got nop %b want 1", cyc, nop_en); end
      end else if (nop_en === 1'b0) begin
        tests++; if (pc_out !== exp_pc || instr_out !== mem_word(exp_pc)) begin
          failed++; $display("FAIL rnd_deliver @%0d: got %h/%h want %h/%h", cyc, pc_out, instr_out, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (prev_flush) exp_pc = tgt_r;

      // Memory responder: address and request must stay put until resp.
      if (outstanding) begin
        tests++; if (imem_read !== 1'b1 || imem_address !== req_addr) begin
          failed++; $display("FAIL rnd_protocol @%0d: got read %b addr %h want 1/%h", cyc, imem_read, imem_address, req_addr);
        end
      end else if (imem_read === 1'b1) begin
        outstanding = 1'b1;
        req_addr    = imem_address;
        wait_cnt    = int'($urandom_range(0, 3));
      end

      stall_n   = ($urandom_range(0, 3) != 0);
      br_flush  = ($urandom_range(0, 9) == 0);
      tgt_r     = $urandom;
      br_target = tgt_r;
      if (outstanding && wait_cnt == 0) begin
        imem_resp  = 1'b1;
        imem_rdata = mem_word(req_addr);
      end else begin
        imem_resp  = 1'b0;
        imem_rdata = $urandom;
        if (outstanding) wait_cnt--;
      end
      prev_flush = br_flush; prev_stall = stall_n; prev_resp = imem_resp;
      snap_pc = pc_out; snap_instr = instr_out; snap_nop = nop_en;
      tick;
    end
    br_flush = 1'b0; imem_resp = 1'b0;
    tests++; if (delivered < 40) begin failed++; $display("FAIL rnd_progress: got %0d deliveries want >= 40", delivered); end
  endtask

  initial begin
    test_reset;
    test_back_to_back;
    test_stall_at_response;
    test_flush_during_miss;
    test_flush_with_resp;
    test_wrap;
    test_unaligned_target;
    test_reset_mid_request;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
